// File: rtl/psram_ctrl_pkg.sv
// Shared types and default timing for the cartridge CRAM access controller.
package psram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    CAPTURE,
    RECOVER
  } state_t;

  typedef enum logic {
    SEL_P0 = 1'b0,
    SEL_P1 = 1'b1
  } port_sel_t;

  localparam int T_ADV_DEF      = 2;
  localparam int T_ACC_DEF      = 7;
  localparam int T_REC_DEF      = 2;
  localparam int STARVE_MAX_DEF = 4;

  // Output IOB flop plus input IOB flop.
  localparam int CAPTURE_CYC = 2;

  // Phase counter holds length-1 of the longest phase.
  function automatic int phase_cnt_w(input int t_adv, input int t_acc, input int t_rec);
    int m;
    m = CAPTURE_CYC;
    if (t_adv > m) m = t_adv;
    if (t_acc > m) m = t_acc;
    if (t_rec > m) m = t_rec;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/psram_req_arb.sv
// Two-port arbiter: port 0 has priority unless port 1 has waited STARVE_MAX grants.
module psram_req_arb
  import psram_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en,
  input  logic      req0,
  input  logic      req1,
  output logic      grant_valid,
  output port_sel_t grant_sel
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved     = (starve_cnt == SW'(STARVE_MAX));
  assign grant_valid = en && (req0 || req1);
  assign grant_sel   = (req1 && (!req0 || starved)) ? SEL_P1 : SEL_P0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_sel == SEL_P1 || !req1)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/psram_access_ctrl.sv
// CRAM single-word access sequencer: arbitrates two requesters and drives the
// multiplexed address/data bus through ADDR, ACCESS, CAPTURE and RECOVER phases.
module psram_access_ctrl
  import psram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int T_ADV      = T_ADV_DEF,
  parameter int T_ACC      = T_ACC_DEF,
  parameter int T_REC      = T_REC_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_ack,
  output logic [15:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ack,
  output logic [15:0]       p1_rdata,
  output logic [ADDR_W-17:0] cram_a,
  output logic [15:0]       cram_dq_out,
  output logic              cram_dq_oe,
  input  logic [15:0]       cram_dq_in,
  output logic              cram_ce_n,
  output logic              cram_adv_n,
  output logic              cram_oe_n,
  output logic              cram_we_n,
  output logic              cram_ub_n,
  output logic              cram_lb_n,
  output logic              busy
);

  localparam int CNT_W = phase_cnt_w(T_ADV, T_ACC, T_REC);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              grant_valid;
  port_sel_t         grant_sel, sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        be_q;
  logic              ack_nxt, capture;

  psram_req_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (state == IDLE),
    .req0        (p0_req),
    .req1        (p1_req),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt != '0) ? cnt - 1'b1 : cnt;
    ack_nxt     = 1'b0;
    capture     = 1'b0;
    cram_ce_n   = 1'b1;
    cram_adv_n  = 1'b1;
    cram_oe_n   = 1'b1;
    cram_we_n   = 1'b1;
    cram_ub_n   = 1'b1;
    cram_lb_n   = 1'b1;
    cram_dq_oe  = 1'b0;
    cram_dq_out = '0;
    cram_a      = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = ADDR;
          cnt_nxt   = CNT_W'(T_ADV - 1);
        end
      end
      ADDR: begin
        cram_ce_n   = 1'b0;
        cram_adv_n  = 1'b0;
        cram_dq_oe  = 1'b1;
        cram_dq_out = addr_q[15:0];
        cram_a      = addr_q[ADDR_W-1:16];
        if (cnt == '0) begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_W'(T_ACC - 1);
        end
      end
      ACCESS: begin
        cram_ce_n = 1'b0;
        cram_a    = addr_q[ADDR_W-1:16];
        cram_ub_n = ~be_q[1];
        cram_lb_n = ~be_q[0];
        if (we_q) begin
          cram_we_n   = 1'b0;
          cram_dq_oe  = 1'b1;
          cram_dq_out = wdata_q;
        end else begin
          cram_oe_n   = 1'b0;
        end
        if (cnt == '0) begin
          if (we_q) begin
            state_nxt = RECOVER;
            cnt_nxt   = CNT_W'(T_REC - 1);
            ack_nxt   = 1'b1;
          end else begin
            state_nxt = CAPTURE;
            cnt_nxt   = CNT_W'(CAPTURE_CYC - 1);
          end
        end
      end
      CAPTURE: begin
        // Read data reaches us two flops after the pins; keep OE asserted.
        cram_ce_n = 1'b0;
        cram_oe_n = 1'b0;
        cram_a    = addr_q[ADDR_W-1:16];
        cram_ub_n = ~be_q[1];
        cram_lb_n = ~be_q[0];
        if (cnt == '0) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = RECOVER;
          cnt_nxt   = CNT_W'(T_REC - 1);
        end
      end
      RECOVER: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel      <= SEL_P0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_ack <= ack_nxt && (sel == SEL_P0);
      p1_ack <= ack_nxt && (sel == SEL_P1);
      if (state == IDLE && grant_valid) begin
        sel     <= grant_sel;
        we_q    <= (grant_sel == SEL_P1) ? p1_we    : p0_we;
        addr_q  <= (grant_sel == SEL_P1) ? p1_addr  : p0_addr;
        wdata_q <= (grant_sel == SEL_P1) ? p1_wdata : p0_wdata;
        be_q    <= (grant_sel == SEL_P1) ? p1_be    : p0_be;
      end
      if (capture) begin
        if (sel == SEL_P0) p0_rdata <= cram_dq_in;
        else               p1_rdata <= cram_dq_in;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
